// File: rtl/circle_tracker.sv
// ---------------------------------------------------------------------------
// circle_tracker
//
// Game-side responder to the rhythm-game state machine. Runs one shrinking
// approach circle per lane (4 lanes), judges key presses as hit or miss, and
// reports resolved circles and the player's health.
//
// Ports
//   Clk            in   1   system clock
//   Reset          in   1   synchronous, active-high reset
//   frame_tick     in   1   one-cycle strobe per video frame; radii shrink on it
//   main           in   1   main screen: clears all lanes, reloads health
//   spawn          in   1   beat strobe (level, may be held for many cycles)
//   circletype     in   2   lane to spawn (0..3)
//   keycode        in   8   current USB HID keycode (0 = none)
//   out_of_bounds  out  1   one-cycle pulse: at least one lane resolved
//   hit_pulse      out  1   one-cycle pulse: at least one hit
//   miss_pulse     out  1   one-cycle pulse: at least one miss
//   health         out  4   current health, saturating 0..HEALTH_MAX
//   active         out  4   bit n = lane n circle live
//   radius         out  32  lane n radius in [8n+7:8n]; 0 when lane idle
//   score          out  16  (only with CIRCLE_TRACKER_SCORE_EN) +10 per hit,
//                           saturating at 16'hFFFF
//
// Configuration
//   CIRCLE_TRACKER_SCORE_EN  define to add the score output and its counter.
// ---------------------------------------------------------------------------
module circle_tracker #(
  parameter logic [7:0] START_RADIUS = 8'd64,
  parameter logic [7:0] HIT_WINDOW   = 8'd12,
  parameter logic [3:0] HEALTH_INIT  = 4'd4,
  parameter logic [3:0] HEALTH_MAX   = 4'd15
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_tick,
  input  logic        main,
  input  logic        spawn,
  input  logic [1:0]  circletype,
  input  logic [7:0]  keycode,
  output logic        out_of_bounds,
  output logic        hit_pulse,
  output logic        miss_pulse,
  output logic [3:0]  health,
  output logic [3:0]  active,
  output logic [31:0] radius
`ifdef CIRCLE_TRACKER_SCORE_EN
  ,
  output logic [15:0] score
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    LIVE = 1'b1
  } lane_state_t;

  // HID keycode bound to each lane: A, S, D, F.
  function automatic logic [7:0] lane_key(input int n);
    case (n)
      0:       lane_key = 8'd4;
      1:       lane_key = 8'd22;
      2:       lane_key = 8'd7;
      default: lane_key = 8'd9;
    endcase
  endfunction

  lane_state_t state      [4];
  lane_state_t state_next [4];
  logic [7:0]  rad        [4];
  logic [7:0]  rad_next   [4];

  logic [7:0]  key_q;     // keycode seen last cycle, for press-edge detection
  logic [3:0]  req;       // spawn request aimed at each lane this cycle
  logic [3:0]  req_q;     // same, last cycle: a held spawn fires only once
  logic [2:0]  hit_cnt;
  logic [2:0]  miss_cnt;
  logic [3:0]  health_next;
  logic signed [6:0] health_sum;

  // Next-state logic for all four lanes plus this cycle's hit/miss tallies.
  // NOTE: every signal gets a default before the branches so no path leaves
  // it unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    hit_cnt  = 3'd0;
    miss_cnt = 3'd0;
    req      = 4'd0;
    for (int n = 0; n < 4; n++) begin
      logic spawn_ev;
      logic press_ev;
      state_next[n] = state[n];
      rad_next[n]   = rad[n];
      req[n]        = spawn && (circletype == 2'(n));
      spawn_ev      = req[n] && !req_q[n];
      press_ev      = (keycode == lane_key(n)) && (key_q != lane_key(n));
      case (state[n])
        IDLE: begin
          if (spawn_ev) begin
            state_next[n] = LIVE;
            rad_next[n]   = START_RADIUS;
          end
        end
        LIVE: begin
          // Checked before expiry so a press on the final tick still hits.
          // Presses outside the window are simply ignored.
          if (press_ev && (rad[n] <= HIT_WINDOW)) begin
            state_next[n] = IDLE;
            rad_next[n]   = 8'd0;
            hit_cnt       = hit_cnt + 3'd1;
          end else if (frame_tick) begin
            if (rad[n] == 8'd0) begin
              state_next[n] = IDLE;
              miss_cnt      = miss_cnt + 3'd1;
            end else begin
              rad_next[n] = rad[n] - 8'd1;
            end
          end
        end
        default: state_next[n] = IDLE;
      endcase
    end

    // Net health change applied once, clamped to [0, HEALTH_MAX].
    health_sum = $signed({3'b000, health}) + $signed({4'b0000, hit_cnt})
               - $signed({4'b0000, miss_cnt});
    if (health_sum < 7'sd0) begin
      health_next = 4'd0;
    end else if (health_sum > $signed({3'b000, HEALTH_MAX})) begin
      health_next = HEALTH_MAX;
    end else begin
      health_next = health_sum[3:0];
    end
  end

  // Reset and main behave the same: lanes dropped silently, no pulses.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Clk) begin
    if (Reset || main) begin
      for (int n = 0; n < 4; n++) begin
        state[n] <= IDLE;
        rad[n]   <= 8'd0;
      end
      key_q         <= 8'd0;
      req_q         <= 4'd0;
      health        <= HEALTH_INIT;
      out_of_bounds <= 1'b0;
      hit_pulse     <= 1'b0;
      miss_pulse    <= 1'b0;
    end else begin
      for (int n = 0; n < 4; n++) begin
        state[n] <= state_next[n];
        rad[n]   <= rad_next[n];
      end
      key_q         <= keycode;
      req_q         <= req;
      health        <= health_next;
      hit_pulse     <= (hit_cnt != 3'd0);
      miss_pulse    <= (miss_cnt != 3'd0);
      out_of_bounds <= (hit_cnt != 3'd0) || (miss_cnt != 3'd0);
    end
  end

`ifdef CIRCLE_TRACKER_SCORE_EN
  logic [16:0] score_sum;
  assign score_sum = {1'b0, score} + (17'(hit_cnt) * 17'd10);

  always_ff @(posedge Clk) begin
    if (Reset || main) begin
      score <= 16'd0;
    end else begin
      score <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
    end
  end
`endif

  always_comb begin
    for (int n = 0; n < 4; n++) begin
      active[n]         = (state[n] == LIVE);
      radius[8*n +: 8]  = rad[n];
    end
  end

endmodule
